// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard sequencer.
// State encoding and the default register index width.
package pipe_hazard_ctrl_pkg;

  localparam int HZ_REG_IDX_W = 5;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_WAIT   = 2'd1,
    HZ_RESUME = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_detect.sv
// Load-use compare between the D-stage sources and the E-stage load.
// Purely combinational; x0 never creates a hazard.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_IDX_W = HZ_REG_IDX_W
) (
  input  logic [REG_IDX_W-1:0] d_rs1_idx_i,
  input  logic [REG_IDX_W-1:0] d_rs2_idx_i,
  input  logic                 d_use_rs1_i,
  input  logic                 d_use_rs2_i,
  input  logic [REG_IDX_W-1:0] e_rd_idx_i,
  input  logic                 e_is_load_i,
  output logic                 load_use_o
);

  logic hit1, hit2;

  assign hit1 = d_use_rs1_i & (d_rs1_idx_i == e_rd_idx_i);
  assign hit2 = d_use_rs2_i & (d_rs2_idx_i == e_rd_idx_i);

  assign load_use_o = e_is_load_i & (e_rd_idx_i != '0)
                    & (hit1 | hit2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer: stall/jb/stop/PReady with miss freeze and watchdog.
// Define HAZARD_PERF_CNT_EN to add the perf counter outputs.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_IDX_W    = HZ_REG_IDX_W,
  parameter int WAIT_TIMEOUT = 1024,
  parameter int WCNT_W       = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] d_rs1_idx,
  input  logic [REG_IDX_W-1:0] d_rs2_idx,
  input  logic                 d_use_rs1,
  input  logic                 d_use_rs2,
  input  logic [REG_IDX_W-1:0] e_rd_idx,
  input  logic                 e_is_load,
  input  logic                 e_jb_taken,
  input  logic                 imem_busy,
  input  logic                 dmem_busy,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]          perf_stop_cycles,
  output logic [31:0]          perf_stall_cycles,
  output logic [31:0]          perf_flush_cnt,
`endif
  output logic                 stall,
  output logic                 jb,
  output logic                 stop,
  output logic                 PReady,
  output logic                 mem_timeout
);

  localparam logic [WCNT_W-1:0] CNT_MAX =
    WCNT_W'(WAIT_TIMEOUT);
  localparam logic [WCNT_W-1:0] CNT_HIT =
    WCNT_W'(WAIT_TIMEOUT - 1);

  hz_state_e         state_q, state_d;
  logic              pend_stall_q, pend_stall_d;
  logic              pend_jb_q, pend_jb_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q;
  logic              load_use, busy, to_hit;
  logic              stall_c, jb_c, stop_c, pready_c;

  hazard_detect #(
    .REG_IDX_W (REG_IDX_W)
  ) u_detect (
    .d_rs1_idx_i (d_rs1_idx),
    .d_rs2_idx_i (d_rs2_idx),
    .d_use_rs1_i (d_use_rs1),
    .d_use_rs2_i (d_use_rs2),
    .e_rd_idx_i  (e_rd_idx),
    .e_is_load_i (e_is_load),
    .load_use_o  (load_use)
  );

  assign busy = imem_busy | dmem_busy;

  always_comb begin
    state_d      = state_q;
    pend_stall_d = pend_stall_q;
    pend_jb_d    = pend_jb_q;
    wait_cnt_d   = wait_cnt_q;
    stall_c      = 1'b0;
    jb_c         = 1'b0;
    stop_c       = 1'b0;
    pready_c     = 1'b0;
    to_hit       = 1'b0;
    unique case (state_q)
      HZ_WAIT: begin
        stop_c       = 1'b1;
        pend_stall_d = pend_stall_q | load_use;
        pend_jb_d    = pend_jb_q | e_jb_taken;
        to_hit       = (wait_cnt_q == CNT_HIT);
        if (wait_cnt_q != CNT_MAX)
          wait_cnt_d = wait_cnt_q + 1'b1;
        if (!busy) begin
          state_d    = HZ_RESUME;
          wait_cnt_d = '0;
        end
      end
      HZ_RESUME: begin
        stop_c = busy;
        if (busy) begin
          // A new miss on the resume cycle keeps the owed decisions.
          state_d      = HZ_WAIT;
          pend_stall_d = pend_stall_q | load_use;
          pend_jb_d    = pend_jb_q | e_jb_taken;
        end else begin
          pready_c     = 1'b1;
          jb_c         = pend_jb_q | e_jb_taken;
          stall_c      = (pend_stall_q | load_use) & ~jb_c;
          pend_stall_d = 1'b0;
          pend_jb_d    = 1'b0;
          state_d      = HZ_RUN;
        end
      end
      default: begin
        stop_c = busy;
        if (busy) begin
          state_d      = HZ_WAIT;
          pend_stall_d = load_use;
          pend_jb_d    = e_jb_taken;
        end else begin
          jb_c    = e_jb_taken;
          stall_c = load_use & ~e_jb_taken;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HZ_RUN;
      pend_stall_q  <= 1'b0;
      pend_jb_q     <= 1'b0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_stall_q  <= pend_stall_d;
      pend_jb_q     <= pend_jb_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_q | to_hit;
    end
  end

  assign stall       = ~rst & stall_c;
  assign jb          = ~rst & jb_c;
  assign stop        = ~rst & stop_c;
  assign PReady      = ~rst & pready_c;
  assign mem_timeout = ~rst & (mem_timeout_q | to_hit);

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stop_cycles  <= '0;
      perf_stall_cycles <= '0;
      perf_flush_cnt    <= '0;
    end else begin
      if (stop && perf_stop_cycles != '1)
        perf_stop_cycles <= perf_stop_cycles + 1'b1;
      if (stall && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (jb && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed plan plus
// randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int W  = 5;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] d_rs1_idx, d_rs2_idx, e_rd_idx;
  logic         d_use_rs1, d_use_rs2;
  logic         e_is_load, e_jb_taken;
  logic         imem_busy, dmem_busy;
  logic         stall, jb, stop, PReady, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]  perf_stop_cycles;
  logic [31:0]  perf_stall_cycles;
  logic [31:0]  perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_IDX_W    (W),
    .WAIT_TIMEOUT (TO),
    .WCNT_W       (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .d_rs1_idx         (d_rs1_idx),
    .d_rs2_idx         (d_rs2_idx),
    .d_use_rs1         (d_use_rs1),
    .d_use_rs2         (d_use_rs2),
    .e_rd_idx          (e_rd_idx),
    .e_is_load         (e_is_load),
    .e_jb_taken        (e_jb_taken),
    .imem_busy         (imem_busy),
    .dmem_busy         (dmem_busy),
`ifdef HAZARD_PERF_CNT_EN
    .perf_stop_cycles  (perf_stop_cycles),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_cnt    (perf_flush_cnt),
`endif
    .stall             (stall),
    .jb                (jb),
    .stop              (stop),
    .PReady            (PReady),
    .mem_timeout       (mem_timeout)
  );

  // Reference model: frozen = inside a freeze, resume = first
  // free cycle after it, owe_* = decisions raised while frozen.
  bit m_frz, m_res, m_oj, m_os, m_to;
  int m_len;
  int m_pstop, m_pstall, m_pflush;

  function automatic bit lu_f();
    bit h1, h2;
    h1 = d_use_rs1 && d_rs1_idx == e_rd_idx;
    h2 = d_use_rs2 && d_rs2_idx == e_rd_idx;
    return e_is_load && e_rd_idx != 0 && (h1 || h2);
  endfunction

  function automatic void model_out(
    output bit s, output bit j, output bit st,
    output bit pr, output bit to);
    bit b;
    b = imem_busy | dmem_busy;
    s = 0; j = 0; st = 0; pr = 0; to = 0;
    if (rst) return;
    if (m_frz) begin
      st = 1;
      to = m_to || (m_len + 1 >= TO);
    end else begin
      st = b;
      pr = m_res && !b;
      to = m_to;
      if (!b) begin
        j = e_jb_taken || (m_res && m_oj);
        s = (lu_f() || (m_res && m_os)) && !j;
      end
    end
  endfunction

  always @(posedge clk) begin
    bit s, j, st, pr, to, b, l;
    b = imem_busy | dmem_busy;
    l = lu_f();
    model_out(s, j, st, pr, to);
    if (rst) begin
      m_frz = 0; m_res = 0; m_oj = 0; m_os = 0;
      m_to = 0; m_len = 0;
      m_pstop = 0; m_pstall = 0; m_pflush = 0;
    end else begin
      m_pstop  += int'(st);
      m_pstall += int'(s);
      m_pflush += int'(j);
      if (m_frz) begin
        m_oj |= e_jb_taken;
        m_os |= l;
        if (to) m_to = 1;
        if (b) m_len++;
        else begin
          m_frz = 0; m_res = 1; m_len = 0;
        end
      end else if (b) begin
        m_frz = 1; m_res = 0; m_len = 0;
        m_oj |= e_jb_taken;
        m_os |= l;
      end else begin
        m_res = 0; m_oj = 0; m_os = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle();
    d_rs1_idx = '0; d_rs2_idx = '0; e_rd_idx = '0;
    d_use_rs1 = 0; d_use_rs2 = 0;
    e_is_load = 0; e_jb_taken = 0;
    imem_busy = 0; dmem_busy = 0;
  endtask

  task automatic reset_dut();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    dmem_busy = 1; e_jb_taken = 1; e_is_load = 1;
    e_rd_idx = 3; d_use_rs1 = 1; d_rs1_idx = 3;
    settle();
    total++;
    if ({stall, jb, stop, PReady, mem_timeout} !== 5'b0) begin
      bad++;
      $display("FAIL reset_hold outs=%b exp=00000",
               {stall, jb, stop, PReady, mem_timeout});
    end
    step();
    rst = 0;
    idle();
    settle();
    total++;
    if ({stall, jb, stop, PReady, mem_timeout} !== 5'b0) begin
      bad++;
      $display("FAIL reset_idle outs=%b exp=00000",
               {stall, jb, stop, PReady, mem_timeout});
    end
  endtask

  task automatic test_load_use();
    reset_dut();
    e_is_load = 1; e_rd_idx = 5;
    d_use_rs2 = 1; d_rs2_idx = 5;
    settle();
    total++;
    if ({stall, jb, stop} !== 3'b100) begin
      bad++;
      $display("FAIL lu_rs2 stall/jb/stop=%b exp=100",
               {stall, jb, stop});
    end
    step();
    e_rd_idx = 0; d_rs2_idx = 0;
    settle();
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL lu_x0 stall=%b exp=0", stall);
    end
    step();
    e_rd_idx = 9; d_use_rs2 = 0;
    d_use_rs1 = 1; d_rs1_idx = 9; d_rs2_idx = 9;
    settle();
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL lu_rs1 stall=%b exp=1", stall);
    end
    step();
    d_use_rs1 = 0;
    settle();
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL lu_nouse stall=%b exp=0", stall);
    end
  endtask

  task automatic test_lu_jump();
    reset_dut();
    e_is_load = 1; e_rd_idx = 7;
    d_use_rs1 = 1; d_rs1_idx = 7; e_jb_taken = 1;
    settle();
    total++;
    if ({stall, jb} !== 2'b01) begin
      bad++;
      $display("FAIL lu_jump stall/jb=%b exp=01", {stall, jb});
    end
  endtask

  task automatic test_miss_pending_jump();
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      dmem_busy = 1; e_jb_taken = 1;
      settle();
      total++;
      if ({stop, jb, stall, PReady} !== 4'b1000) begin
        bad++;
        $display("FAIL miss_busy%0d stop/jb/stall/pr=%b exp=1000",
                 i, {stop, jb, stall, PReady});
      end
      step();
    end
    dmem_busy = 0; e_jb_taken = 0;
    settle();
    total++;
    if ({stop, jb, PReady} !== 3'b100) begin
      bad++;
      $display("FAIL miss_release stop/jb/pr=%b exp=100",
               {stop, jb, PReady});
    end
    step();
    settle();
    total++;
    if ({stop, jb, stall, PReady} !== 4'b0101) begin
      bad++;
      $display("FAIL miss_resume stop/jb/stall/pr=%b exp=0101",
               {stop, jb, stall, PReady});
    end
    step();
    settle();
    total++;
    if ({jb, PReady} !== 2'b00) begin
      bad++;
      $display("FAIL miss_after jb/pr=%b exp=00", {jb, PReady});
    end
    step();
    e_jb_taken = 1;
    settle();
    total++;
    if ({jb, PReady} !== 2'b10) begin
      bad++;
      $display("FAIL miss_follow jb/pr=%b exp=10", {jb, PReady});
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    imem_busy = 1; e_jb_taken = 1;
    step();
    e_jb_taken = 0;
    step();
    imem_busy = 0;
    settle();
    total++;
    if (stop !== 1'b1) begin
      bad++;
      $display("FAIL b2b_release stop=%b exp=1", stop);
    end
    step();
    imem_busy = 1;
    settle();
    total++;
    if ({stop, PReady, jb} !== 3'b100) begin
      bad++;
      $display("FAIL b2b_remiss stop/pr/jb=%b exp=100",
               {stop, PReady, jb});
    end
    step();
    imem_busy = 0;
    settle();
    total++;
    if ({stop, PReady} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_release2 stop/pr=%b exp=10",
               {stop, PReady});
    end
    step();
    settle();
    total++;
    if ({stop, PReady, jb, stall} !== 4'b0110) begin
      bad++;
      $display("FAIL b2b_resume stop/pr/jb/stall=%b exp=0110",
               {stop, PReady, jb, stall});
    end
  endtask

  task automatic test_watchdog();
    reset_dut();
    imem_busy = 1;
    for (int c = 0; c < 20; c++) begin
      settle();
      total++;
      if (mem_timeout !== (c >= TO)) begin
        bad++;
        $display("FAIL wd_cyc%0d mem_timeout=%b exp=%b",
                 c, mem_timeout, (c >= TO));
      end
      step();
    end
    imem_busy = 0;
    for (int c = 0; c < 3; c++) begin
      settle();
      total++;
      if (mem_timeout !== 1'b1) begin
        bad++;
        $display("FAIL wd_sticky%0d mem_timeout=%b exp=1",
                 c, mem_timeout);
      end
      step();
    end
    rst = 1;
    settle();
    step();
    rst = 0;
    settle();
    total++;
    if (mem_timeout !== 1'b0) begin
      bad++;
      $display("FAIL wd_clear mem_timeout=%b exp=0", mem_timeout);
    end
  endtask

  task automatic test_reset_mid_wait();
    reset_dut();
    dmem_busy = 1; e_jb_taken = 1;
    e_is_load = 1; e_rd_idx = 4;
    d_use_rs1 = 1; d_rs1_idx = 4;
    step();
    step();
    step();
    rst = 1;
    settle();
    total++;
    if ({stall, jb, stop, PReady, mem_timeout} !== 5'b0) begin
      bad++;
      $display("FAIL rmw_hold outs=%b exp=00000",
               {stall, jb, stop, PReady, mem_timeout});
    end
    step();
    rst = 0;
    idle();
    settle();
    total++;
    if ({stall, jb, stop, PReady} !== 4'b0) begin
      bad++;
      $display("FAIL rmw_after outs=%b exp=0000",
               {stall, jb, stop, PReady});
    end
`ifdef HAZARD_PERF_CNT_EN
    total++;
    if ({perf_stop_cycles, perf_stall_cycles, perf_flush_cnt}
        !== 96'd0) begin
      bad++;
      $display("FAIL rmw_perf stop=%0d stall=%0d flush=%0d exp=0",
               perf_stop_cycles, perf_stall_cycles,
               perf_flush_cnt);
    end
`endif
  endtask

  task automatic test_random();
    int burst;
    bit prev_pr, s, j, st, pr, to;
    burst = 0;
    prev_pr = 0;
    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      d_rs1_idx = W'($urandom_range(0, 3));
      d_rs2_idx = W'($urandom_range(0, 3));
      e_rd_idx  = W'($urandom_range(0, 3));
      d_use_rs1 = 1'($urandom);
      d_use_rs2 = 1'($urandom);
      e_is_load = 1'($urandom);
      e_jb_taken = ($urandom_range(0, 3) == 0);
      imem_busy = ($urandom_range(0, 7) == 0);
      if (burst == 0 && $urandom_range(0, 9) == 0)
        burst = $urandom_range(1, 12);
      dmem_busy = (burst > 0);
      if (burst > 0) burst--;
      settle();
      model_out(s, j, st, pr, to);
      total++;
      if ({stall, jb, stop, PReady, mem_timeout}
          !== {s, j, st, pr, to}) begin
        bad++;
        if (bad < 40)
          $display("FAIL rand%0d outs=%b exp=%b", n,
                   {stall, jb, stop, PReady, mem_timeout},
                   {s, j, st, pr, to});
      end
      total++;
      if ((stop && (stall || jb)) || (stall && jb)
          || (prev_pr && PReady)) begin
        bad++;
        if (bad < 40)
          $display("FAIL inv%0d stop/stall/jb/pr=%b prev_pr=%b",
                   n, {stop, stall, jb, PReady}, prev_pr);
      end
`ifdef HAZARD_PERF_CNT_EN
      total++;
      if (perf_stop_cycles !== 32'(m_pstop)
          || perf_stall_cycles !== 32'(m_pstall)
          || perf_flush_cnt !== 32'(m_pflush)) begin
        bad++;
        if (bad < 40)
          $display("FAIL perf%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                   n, perf_stop_cycles, perf_stall_cycles,
                   perf_flush_cnt, m_pstop, m_pstall, m_pflush);
      end
`endif
      prev_pr = PReady;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_lu_jump();
    test_miss_pending_jump();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
